mem_burst_responder: RTL
========================

MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  ADDR_WIDTH, 32, byte address width
  DATA_WIDTH, 32, beat width; one word per beat
  BLOCK_WORDS, 16, beats per cache block; power of 2, >= 2
  MEM_DEPTH, 1024, backing store depth in words; power of 2
  READ_LATENCY, 2, idle cycles between read acceptance and first beat; >= 1
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  clock
  arstn  in  1  reset, asynchronous, active-low
  i_start_read  in  1  level request for a block fill; held until o_r_last
  i_start_write  in  1  level request for a block write-back; held until o_b_resp
  i_addr  in  ADDR_WIDTH  byte address of the block
  i_w_data  in  DATA_WIDTH  write-back beat, valid whenever o_w_ready=1
  o_w_ready  out  1  write beat consumed this cycle
  o_r_data  out  DATA_WIDTH  read beat
  o_r_valid  out  1  o_r_data valid this cycle
  o_r_last  out  1  final read beat; coincides with o_r_valid
  o_b_resp  out  1  one-cycle pulse, write-back complete

Function
REQ-003 States: IDLE, R_WAIT, R_BURST, W_BURST, W_RESP.
REQ-004 IDLE: i_start_write=1 -> W_BURST; else i_start_read=1 -> R_WAIT. Write has priority when both are high.
REQ-005 On acceptance, latch the base word index = (i_addr >> log2(DATA_WIDTH/8)) with the low log2(BLOCK_WORDS) bits cleared, modulo MEM_DEPTH. i_addr is ignored after acceptance.
REQ-006 Beat counter is log2(BLOCK_WORDS) bits and is cleared on acceptance. Beat k addresses (base + k) mod MEM_DEPTH.
REQ-007 R_WAIT lasts exactly READ_LATENCY cycles (latency counter), then -> R_BURST.
REQ-008 R_BURST: o_r_valid=1 for BLOCK_WORDS consecutive cycles, with o_r_data = mem[base+k] on beat k. o_r_last=1 only on beat BLOCK_WORDS-1. The cycle after the last beat, the block is in IDLE.
REQ-009 W_BURST: o_w_ready=1 for BLOCK_WORDS consecutive cycles. i_w_data is written to mem[base+k] at the clock edge ending beat k. After the last beat -> W_RESP.
REQ-010 W_RESP: o_b_resp=1 for exactly one cycle -> IDLE.
REQ-011 Read latency: first o_r_valid appears READ_LATENCY+1 cycles after the accepting edge. The full fill takes READ_LATENCY+BLOCK_WORDS cycles in non-IDLE states.
REQ-012 A write-back followed by a fill of the same block returns the newly written data. This requires no write-read hazard: the write completes before W_RESP.
REQ-013 A request deasserted mid-transaction is ignored; the transaction runs to completion. A request still high in IDLE after completion starts a new transaction. The requester's protocol makes this impossible under normal operation.
REQ-014 o_r_valid, o_r_last, o_w_ready and o_b_resp are 0 in every state other than the one that drives them.
REQ-015 Outputs are registered or decoded from the state register only; no combinational path from any input to any output.

Reset
REQ-016 arstn=0 forces IDLE, clears the beat and latency counters, and clears the latched base. All outputs become 0, including o_r_data.
REQ-017 Reset mid-burst aborts the transaction. No further beats or o_b_resp are produced. Words written before reset are retained.
REQ-018 Memory contents are not reset.

Structure
REQ-019 A shared package holds the state enum typedef and the default parameter constants.
REQ-020 One sub-module, mem_block_ram: a single-port synchronous RAM (MEM_DEPTH x DATA_WIDTH) with a registered read port. The FSM issues the read address one cycle ahead so o_r_data aligns with o_r_valid.

Verification
REQ-021 Fill: i_addr=0x0000_0040 with mem preloaded mem[i]=i. Required: after 2 idle cycles, 16 beats return 0x10..0x1F; o_r_last on 0x1F; then IDLE.
REQ-022 Write-back then fill: write 16 beats 0xA0+k to i_addr=0x80. Required: one-cycle o_b_resp; then a fill of 0x80 returns 0xA0..0xAF.
REQ-023 Simultaneous i_start_read=i_start_write=1 in IDLE. Required: o_w_ready is asserted first and no o_r_valid appears before o_b_resp.
REQ-024 Wrap: i_addr = byte address of word MEM_DEPTH-16. Required: beats cover indices 1008..1023 only; unaligned i_addr=0x44 returns the block at word 16.
REQ-025 Reset at read beat 5. Required: all outputs 0 within the reset cycle; after release there is no activity until a new request, and the next fill returns correct data.
REQ-026 i_start_read dropped during R_WAIT. Required: all 16 beats are still delivered, then IDLE with no restart.

Source files
------------

// File: rtl/mem_burst_responder_pkg.sv
// ============================================================================
// Module      : mem_burst_responder_pkg
// Description : Shared types and default parameter values for the
//               block-burst memory responder (FSM state encoding, defaults).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_burst_responder_pkg;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_BLOCK_WORDS  = 16;
    localparam int DEF_MEM_DEPTH    = 1024;
    localparam int DEF_READ_LATENCY = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_R_WAIT  = 3'd1,
        ST_R_BURST = 3'd2,
        ST_W_BURST = 3'd3,
        ST_W_RESP  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_block_ram.sv
// ============================================================================
// Module      : mem_block_ram
// Description : Single-port synchronous RAM, DEPTH x WIDTH, registered read.
//               Array contents are never reset; only the read register is.
// Ports       : clk    - clock
//               arstn  - asynchronous active-low reset (read register only)
//               we     - write enable, writes wdata to mem[addr]
//               re     - read enable, loads mem[addr] into rdata
//               addr   - word address
//               wdata  - write data
//               rdata  - registered read data (holds when re=0)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_block_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Holding rdata when not reading keeps the output quiet outside bursts.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_burst_responder.sv
// ============================================================================
// Module      : mem_burst_responder
// Description : Memory-side responder for cache block fills and write-backs.
//               Serves one BLOCK_WORDS-beat burst per request from an internal
//               single-port RAM; reads start READ_LATENCY cycles after
//               acceptance, write-backs end with a one-cycle response pulse.
// Ports       : clk           - clock
//               arstn         - asynchronous active-low reset
//               i_start_read  - block fill request (level)
//               i_start_write - block write-back request (level, has priority)
//               i_addr        - byte address of the block (sampled on accept)
//               i_w_data      - write-back beat, consumed when o_w_ready=1
//               o_w_ready     - write beat consumed this cycle
//               o_r_data      - read beat data
//               o_r_valid     - read beat valid
//               o_r_last      - final read beat
//               o_b_resp      - write-back complete pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_burst_responder
    import mem_burst_responder_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BLOCK_WORDS  = DEF_BLOCK_WORDS,
    parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_start_read,
    input  logic                  i_start_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    output logic                  o_w_ready,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic                  o_r_valid,
    output logic                  o_r_last,
    output logic                  o_b_resp
);

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int BEAT_W     = $clog2(BLOCK_WORDS);
    localparam int MEM_AW     = $clog2(MEM_DEPTH);
    localparam int LAT_W      = $clog2(READ_LATENCY + 1);

    state_t              state;
    state_t              state_nxt;
    logic [BEAT_W-1:0]   beat;
    logic [LAT_W-1:0]    lat_cnt;
    logic [MEM_AW-1:0]   base;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [MEM_AW-1:0]     base_in;
    logic [MEM_AW-1:0]     beat_ext;
    logic                  last_beat;
    logic                  lat_done;
    logic                  accept;

    logic                  ram_we;
    logic                  ram_re;
    logic [MEM_AW-1:0]     ram_addr;

    // Block-aligned word index of the request, wrapped into the RAM.
    assign word_idx = i_addr >> BYTE_SHIFT;
    assign base_in  = {word_idx[MEM_AW-1:BEAT_W], {BEAT_W{1'b0}}};

    logic unused_word_bits;
    assign unused_word_bits = ^{word_idx[ADDR_WIDTH-1:MEM_AW], word_idx[BEAT_W-1:0]};

    assign beat_ext  = MEM_AW'(beat);
    assign last_beat = &beat;
    assign lat_done  = (lat_cnt == LAT_W'(READ_LATENCY - 1));
    assign accept    = (state == ST_IDLE) && (i_start_write || i_start_read);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_start_write) begin
                    state_nxt = ST_W_BURST;
                end else if (i_start_read) begin
                    state_nxt = ST_R_WAIT;
                end
            end
            ST_R_WAIT:  if (lat_done)  state_nxt = ST_R_BURST;
            ST_R_BURST: if (last_beat) state_nxt = ST_IDLE;
            ST_W_BURST: if (last_beat) state_nxt = ST_W_RESP;
            ST_W_RESP:                 state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        o_r_valid = 1'b0;
        o_r_last  = 1'b0;
        o_w_ready = 1'b0;
        o_b_resp  = 1'b0;
        case (state)
            ST_R_BURST: begin
                o_r_valid = 1'b1;
                o_r_last  = last_beat;
            end
            ST_W_BURST: o_w_ready = 1'b1;
            ST_W_RESP:  o_b_resp  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- burst datapath ----------------
    // Counters stay at zero in IDLE, so they are clear on every acceptance.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            base    <= '0;
            beat    <= '0;
            lat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    beat    <= '0;
                    lat_cnt <= '0;
                    if (accept) begin
                        base <= base_in;
                    end
                end
                ST_R_WAIT:               lat_cnt <= lat_cnt + LAT_W'(1);
                ST_R_BURST, ST_W_BURST:  beat    <= beat + BEAT_W'(1);
                default: ;
            endcase
        end
    end

    // RAM read runs one word ahead of the beat counter: the last R_WAIT cycle
    // fetches beat 0 and beat k fetches beat k+1, so the registered read data
    // lines up with o_r_valid. No fetch is needed on the final beat.
    always_comb begin
        ram_we   = (state == ST_W_BURST);
        ram_re   = 1'b0;
        ram_addr = base + beat_ext;
        case (state)
            ST_R_WAIT: begin
                ram_re   = 1'b1;
                ram_addr = base;
            end
            ST_R_BURST: begin
                ram_re   = !last_beat;
                ram_addr = base + beat_ext + MEM_AW'(1);
            end
            default: ;
        endcase
    end

    mem_block_ram #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .arstn (arstn),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (i_w_data),
        .rdata (o_r_data)
    );

endmodule

`default_nettype wire
